axi_lite_encap: RTL and testbench

- Self-contained AXI4-Lite subsystem: an internal AXI4-Lite master and an internal register-file slave, joined by an axi_intf channel bundle.
- Changes on the simple user-side address/data inputs are turned into AXI-Lite write or read transactions.
- Read data is returned on data_out.
- Used as a protocol-exercise block and as a loopback target in system-level benches.

---
 rtl/axi_lite_encap.sv | 215 +++++++++++++++++++++
 tb/tb_axi_lite_encap.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_encap.sv
// AXI4-Lite loopback subsystem: a user-driven master FSM and a register-file slave on one internal channel set.
// Optional range checking with SLVERR responses and an err output is enabled by defining AXI_ENCAP_SLVERR_EN.
module axi_lite_encap #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_done,
  output logic                  rd_done
`ifdef AXI_ENCAP_SLVERR_EN
  ,
  output logic                  err
`endif
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  // axi_intf channel bundle
  logic                  awvalid, awready;
  logic [ADDR_WIDTH-1:0] ch_awaddr;
  logic                  wvalid, wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  bvalid, bready;
  logic [1:0]            bresp;
  logic                  arvalid, arready;
  logic [ADDR_WIDTH-1:0] ch_araddr;
  logic                  rvalid, rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  assign wstrb = '1;

  // ---------------- master ----------------
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] last_wr_addr, last_rd_addr;
  logic [DATA_WIDTH-1:0] last_wr_data;
  logic                  wr_pend, rd_pend;

  assign wr_pend = {awaddr, data_in} != {last_wr_addr, last_wr_data};
  assign rd_pend = araddr != last_rd_addr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      ch_awaddr    <= '0;
      wdata        <= '0;
      ch_araddr    <= '0;
      last_wr_addr <= '0;
      last_wr_data <= '0;
      last_rd_addr <= '0;
      data_out     <= '0;
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
`ifdef AXI_ENCAP_SLVERR_EN
      err          <= 1'b0;
`endif
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
`ifdef AXI_ENCAP_SLVERR_EN
      err     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wr_pend) begin
            last_wr_addr <= awaddr;
            last_wr_data <= data_in;
            ch_awaddr    <= awaddr;
            wdata        <= data_in;
            awvalid      <= 1'b1;
            wvalid       <= 1'b1;
            state        <= WR_REQ;
          end else if (rd_pend) begin
            last_rd_addr <= araddr;
            ch_araddr    <= araddr;
            arvalid      <= 1'b1;
            state        <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          // each channel is finished once its valid is gone or it handshakes now
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            wr_done <= 1'b1;
`ifdef AXI_ENCAP_SLVERR_EN
            err     <= (bresp == 2'b10);
`endif
            state   <= IDLE;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rvalid) begin
            rready   <= 1'b0;
            data_out <= rdata;
            rd_done  <= 1'b1;
`ifdef AXI_ENCAP_SLVERR_EN
            err      <= (rresp == 2'b10);
`endif
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- slave ----------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  aw_hs, w_hs, wr_fire;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [STRB_W-1:0]     cur_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;

  assign awready  = !bvalid && !aw_held;
  assign wready   = !bvalid && !w_held;
  assign arready  = !rvalid;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign wr_fire  = (aw_hs || aw_held) && (w_hs || w_held);
  assign cur_addr = aw_held ? aw_addr_q : ch_awaddr;
  assign cur_data = w_held ? w_data_q : wdata;
  assign cur_strb = w_held ? w_strb_q : wstrb;
  assign wr_idx   = cur_addr[IDX_W+1:2];
  assign rd_idx   = ch_araddr[IDX_W+1:2];

`ifdef AXI_ENCAP_SLVERR_EN
  assign wr_in_range = (cur_addr >> (IDX_W + 2)) == '0;
  assign rd_in_range = (ch_araddr >> (IDX_W + 2)) == '0;
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= 2'b00;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (wr_fire) begin
        if (wr_in_range) begin
          for (int b = 0; b < STRB_W; b++)
            if (cur_strb[b]) mem[wr_idx][8*b +: 8] <= cur_data[8*b +: 8];
        end
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_in_range ? 2'b00 : 2'b10;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= ch_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end

      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_in_range ? mem[rd_idx] : '0;
        rresp  <= rd_in_range ? 2'b00 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_encap.sv
// Randomized self-checking bench for axi_lite_encap against a word-array model of the register file.
// Build with AXI_ENCAP_SLVERR_EN defined to exercise the out-of-range response path.
module tb_axi_lite_encap;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          wr_done, rd_done;
`ifdef AXI_ENCAP_SLVERR_EN
  logic          err;
`endif

  axi_lite_encap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .awaddr   (awaddr),
    .data_in  (data_in),
    .araddr   (araddr),
    .data_out (data_out),
    .wr_done  (wr_done),
`ifdef AXI_ENCAP_SLVERR_EN
    .rd_done  (rd_done),
    .err      (err)
`else
    .rd_done  (rd_done)
`endif
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_last_wa, m_last_ra;
  logic [DW-1:0] m_last_wd;
  bit            slverr_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(input logic [AW-1:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit m_in_range(input logic [AW-1:0] a);
    return !slverr_mode || (a < DEPTH * 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_last_wa = '0;
    m_last_wd = '0;
    m_last_ra = '0;
  endtask

  task automatic wait_done(input bit rd, output int lat, output logic e);
    lat = 0;
    e   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge aclk); #1;
      if (rd ? rd_done : wr_done) begin
        lat = i;
`ifdef AXI_ENCAP_SLVERR_EN
        e = err;
`endif
        break;
      end
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   lat;
    logic e;
    if (a == m_last_wa && d == m_last_wd) return;
    @(negedge aclk);
    awaddr  = a;
    data_in = d;
    wait_done(1'b0, lat, e);
    chk("wr_latency", lat, 3);
`ifdef AXI_ENCAP_SLVERR_EN
    chk("wr_err", e, !m_in_range(a));
    chk("bresp", dut.bresp, m_in_range(a) ? 2'b00 : 2'b10);
`endif
    @(posedge aclk); #1;
    chk("wr_done_one_cycle", wr_done, 0);
    m_last_wa = a;
    m_last_wd = d;
    if (m_in_range(a)) m_mem[m_idx(a)] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int            lat;
    logic          e;
    logic [DW-1:0] exp_d;
    exp_d = m_in_range(a) ? m_mem[m_idx(a)] : '0;
    @(negedge aclk);
    araddr = a;
    wait_done(1'b1, lat, e);
    chk("rd_latency", lat, 3);
    chk("rd_data", data_out, exp_d);
`ifdef AXI_ENCAP_SLVERR_EN
    chk("rd_err", e, !m_in_range(a));
`endif
    @(posedge aclk); #1;
    chk("rd_done_one_cycle", rd_done, 0);
    m_last_ra = a;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected end of test");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int            lat;
    logic          e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

`ifdef AXI_ENCAP_SLVERR_EN
    slverr_mode = 1'b1;
`else
    slverr_mode = 1'b0;
`endif

    // reset held three cycles with quiet inputs
    areset  = 1'b1;
    awaddr  = '0;
    data_in = '0;
    araddr  = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      chk("rst_data_out", data_out, 0);
      chk("rst_done", {wr_done, rd_done}, 0);
      chk("rst_valids", {dut.awvalid, dut.wvalid, dut.arvalid}, 0);
    end
    @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      chk("idle_after_rst", {wr_done, rd_done, dut.awvalid, dut.arvalid}, 0);
    end

    // directed write then read of the same word
    do_write(32'h0000_0004, 32'hDEAD_BEEF);
    do_read(32'h0000_0004);

    // write and read change together: write goes first, read sees its data
    @(negedge aclk);
    awaddr  = 32'h0000_0020;
    data_in = 32'hCAFE_F00D;
    araddr  = 32'h0000_0020;
    wait_done(1'b0, lat, e);
    chk("both_wr_latency", lat, 3);
    m_last_wa = 32'h0000_0020;
    m_last_wd = 32'hCAFE_F00D;
    m_mem[m_idx(32'h0000_0020)] = 32'hCAFE_F00D;
    wait_done(1'b1, lat, e);
    chk("both_rd_seen", lat != 0, 1);
    chk("both_rd_data", data_out, 32'hCAFE_F00D);
    m_last_ra = 32'h0000_0020;

    // random writes, each read back through its own (possibly aliased) address
    for (int i = 0; i < 5; i++) begin
      a = (i % 2 == 1) ? AW'($urandom) : AW'($urandom_range(0, 63));
      if (a == m_last_ra) a = a ^ 32'h4;
      d = DW'($urandom);
      do_write(a, d);
      repeat (2) @(posedge aclk);
      do_read(a);
    end

    // cross-alias read: word written at a low address, read back from a high alias
    do_write(32'h0000_0008, 32'h1357_9BDF);
    do_read(32'h0000_0008 + DEPTH * 4 * 3);

    // reset while the write request is on the channel
    @(negedge aclk);
    awaddr  = 32'h0000_0008;
    data_in = 32'h1234_5678;
    @(posedge aclk); #1;
    chk("in_wr_req", {dut.awvalid, dut.wvalid}, 2'b11);
    areset  = 1'b1;
    awaddr  = '0;
    data_in = '0;
    araddr  = '0;
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    chk("abort_valids", {dut.awvalid, dut.wvalid, dut.bvalid}, 0);
    for (int i = 0; i < DEPTH; i++) chk("abort_mem_zero", dut.mem[i], 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      chk("abort_no_done", {wr_done, rd_done}, 0);
    end
    do_read(32'h0000_0008);

    // out-of-range address: SLVERR when checked, otherwise aliases onto word 0
    do_write(32'h1000_0000, 32'hA5A5_5A5A);
    do_read(32'h0000_0000);
    do_read(32'h1000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
